// File: rtl/cpu_pkg.sv
// Shared definitions for the multicycle controller: opcodes, ALU op codes,
// FSM state encoding, instruction field positions and an imm8 sign-extender.
package cpu_pkg;

   localparam logic [2:0] OPC_MOV  = 3'b000;
   localparam logic [2:0] OPC_ALU  = 3'b001;
   localparam logic [2:0] OPC_CMP  = 3'b010;
   localparam logic [2:0] OPC_BEQ  = 3'b011;
   localparam logic [2:0] OPC_B    = 3'b100;
   localparam logic [2:0] OPC_HALT = 3'b111;

   localparam logic [1:0] ALU_ADD  = 2'b00;
   localparam logic [1:0] ALU_SUB  = 2'b01;
   localparam logic [1:0] ALU_AND  = 2'b10;
   localparam logic [1:0] ALU_NOTB = 2'b11;

   localparam int OPC_MSB = 15;
   localparam int OPC_LSB = 13;
   localparam int AOP_MSB = 12;
   localparam int AOP_LSB = 11;
   localparam int RD_MSB  = 10;
   localparam int RD_LSB  = 8;
   localparam int RN_MSB  = 7;
   localparam int RN_LSB  = 5;
   localparam int RM_MSB  = 2;
   localparam int RM_LSB  = 0;
   localparam int IMM_MSB = 7;
   localparam int IMM_LSB = 0;

   typedef enum logic [2:0] {
      ST_FETCH, ST_DECODE, ST_READ_A, ST_READ_B,
      ST_EXEC, ST_WB, ST_BRANCH, ST_HALT
   } state_e;

   typedef enum logic [2:0] {
      CLS_MOV, CLS_ALU, CLS_CMP, CLS_BEQ, CLS_B, CLS_HALT, CLS_ILLEGAL
   } instr_cls_e;

   function automatic logic [15:0] sx_imm8(input logic [7:0] imm);
      return {{8{imm[7]}}, imm};
   endfunction

endpackage

// File: rtl/cpu_mem_if.sv
// Instruction-fetch read handshake between the controller (master) and memory.
interface cpu_mem_if #(
   parameter int PC_W = 8
);
   logic            mem_rd;
   logic [PC_W-1:0] mem_addr;
   logic            mem_valid;
   logic [15:0]     mem_rdata;

   modport master (output mem_rd, mem_addr, input mem_valid, mem_rdata);
   modport slave  (input mem_rd, mem_addr, output mem_valid, mem_rdata);
endinterface

// File: rtl/cpu_instr_decode.sv
// Combinational field extraction and opcode classification of the held IR.
module cpu_instr_decode
   import cpu_pkg::*;
(
   input  logic [15:0] ir,
   output instr_cls_e  cls,
   output logic [1:0]  aop,
   output logic [2:0]  rd,
   output logic [2:0]  rn,
   output logic [2:0]  rm,
   output logic [15:0] imm16
);

   logic unused_ir_bits;

   assign aop   = ir[AOP_MSB:AOP_LSB];
   assign rd    = ir[RD_MSB:RD_LSB];
   assign rn    = ir[RN_MSB:RN_LSB];
   assign rm    = ir[RM_MSB:RM_LSB];
   assign imm16 = sx_imm8(ir[IMM_MSB:IMM_LSB]);
   assign unused_ir_bits = ^ir[4:3];

   always_comb begin
      cls = CLS_ILLEGAL;
      case (ir[OPC_MSB:OPC_LSB])
         OPC_MOV:  cls = CLS_MOV;
         OPC_ALU:  cls = CLS_ALU;
         OPC_CMP:  cls = CLS_CMP;
         OPC_BEQ:  cls = CLS_BEQ;
         OPC_B:    cls = CLS_B;
         OPC_HALT: cls = CLS_HALT;
         default:  cls = CLS_ILLEGAL;
      endcase
   end

endmodule

// File: rtl/cpu_controller.sv
// Multicycle control FSM: fetch, decode and sequence the datapath strobes.
// Optional trap on opcodes 101/110 is enabled by CPU_CTRL_ILLEGAL_TRAP_EN.
//
// state     | meaning
// FETCH     | mem_rd high, wait for mem_valid, latch IR, pc+1
// DECODE    | classify IR and pick the instruction path
// READ_A    | rf_rd_num=Rn, load A
// READ_B    | rf_rd_num=Rm, load B
// EXEC      | drive alu_op, load C and Z (CMP forces SUB)
// WB        | write Rd from imm16 (MOV) or C (ALU)
// BRANCH    | pc += sx(imm8) for B, or BEQ with z_flag set
// HALT      | absorbing, all strobes low, halted high
module cpu_controller
   import cpu_pkg::*;
#(
   parameter int              PC_W     = 8,
   parameter logic [PC_W-1:0] RESET_PC = '0
)(
   input  logic        clk,
   input  logic        reset_n,
   cpu_mem_if.master   mem,
   input  logic        z_flag,
   output logic [2:0]  rf_rd_num,
   output logic [2:0]  rf_wr_num,
   output logic        rf_write,
   output logic        load_a,
   output logic        load_b,
   output logic        load_c,
   output logic        load_z,
   output logic [1:0]  alu_op,
   output logic        wb_sel_imm,
   output logic [15:0] imm16,
   output logic        halted,
   output logic        illegal
);

   state_e          state_q, state_d;
   logic [PC_W-1:0] pc_q, pc_d;
   logic [15:0]     ir_q, ir_d;
   logic            run_q;
   logic            mem_rd_s;

   instr_cls_e      cls;
   logic [1:0]      dec_aop;
   logic [2:0]      dec_rd, dec_rn, dec_rm;
   logic [PC_W-1:0] br_off;

   cpu_instr_decode u_dec (
      .ir    (ir_q),
      .cls   (cls),
      .aop   (dec_aop),
      .rd    (dec_rd),
      .rn    (dec_rn),
      .rm    (dec_rm),
      .imm16 (imm16)
   );

   assign br_off       = PC_W'($signed(imm16));
   assign mem.mem_rd   = mem_rd_s;
   assign mem.mem_addr = pc_q;
   assign halted       = (state_q == ST_HALT);

   // run_q keeps mem_rd low during reset and rises one cycle after release
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         state_q <= ST_FETCH;
         pc_q    <= RESET_PC;
         ir_q    <= '0;
         run_q   <= 1'b0;
      end else begin
         state_q <= state_d;
         pc_q    <= pc_d;
         ir_q    <= ir_d;
         run_q   <= 1'b1;
      end
   end

   always_comb begin
      state_d    = state_q;
      pc_d       = pc_q;
      ir_d       = ir_q;
      mem_rd_s   = 1'b0;
      rf_rd_num  = '0;
      rf_wr_num  = '0;
      rf_write   = 1'b0;
      load_a     = 1'b0;
      load_b     = 1'b0;
      load_c     = 1'b0;
      load_z     = 1'b0;
      alu_op     = ALU_ADD;
      wb_sel_imm = 1'b0;
      case (state_q)
         ST_FETCH: begin
            mem_rd_s = run_q;
            if (run_q && mem.mem_valid) begin
               ir_d    = mem.mem_rdata;
               pc_d    = pc_q + PC_W'(1);
               state_d = ST_DECODE;
            end
         end
         ST_DECODE: begin
            case (cls)
               CLS_MOV:          state_d = ST_WB;
               CLS_ALU, CLS_CMP: state_d = ST_READ_A;
               CLS_BEQ, CLS_B:   state_d = ST_BRANCH;
               CLS_HALT:         state_d = ST_HALT;
`ifdef CPU_CTRL_ILLEGAL_TRAP_EN
               default:          state_d = ST_HALT;
`else
               default:          state_d = ST_FETCH;
`endif
            endcase
         end
         ST_READ_A: begin
            rf_rd_num = dec_rn;
            load_a    = 1'b1;
            state_d   = ST_READ_B;
         end
         ST_READ_B: begin
            rf_rd_num = dec_rm;
            load_b    = 1'b1;
            state_d   = ST_EXEC;
         end
         ST_EXEC: begin
            alu_op  = (cls == CLS_CMP) ? ALU_SUB : dec_aop;
            load_c  = 1'b1;
            load_z  = 1'b1;
            state_d = (cls == CLS_CMP) ? ST_FETCH : ST_WB;
         end
         ST_WB: begin
            rf_write   = 1'b1;
            rf_wr_num  = dec_rd;
            wb_sel_imm = (cls == CLS_MOV);
            state_d    = ST_FETCH;
         end
         ST_BRANCH: begin
            // pc already points past the branch, so the offset is relative to pc+1
            if (cls == CLS_B || (cls == CLS_BEQ && z_flag))
               pc_d = pc_q + br_off;
            state_d = ST_FETCH;
         end
         default: state_d = ST_HALT;
      endcase
   end

`ifdef CPU_CTRL_ILLEGAL_TRAP_EN
   logic illegal_q;

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n)
         illegal_q <= 1'b0;
      else if (state_q == ST_DECODE && cls == CLS_ILLEGAL)
         illegal_q <= 1'b1;
   end

   assign illegal = illegal_q;
`else
   assign illegal = 1'b0;
`endif

endmodule

// File: tb/tb_cpu_controller.sv
// Directed bench for cpu_controller: acts as instruction memory and datapath
// Z source, checking strobes cycle by cycle against hand-computed values.
module tb_cpu_controller;
   import cpu_pkg::*;

   logic        clk = 1'b0;
   logic        reset_n;
   logic        z_flag;
   logic [2:0]  rf_rd_num, rf_wr_num;
   logic        rf_write, load_a, load_b, load_c, load_z;
   logic [1:0]  alu_op;
   logic        wb_sel_imm;
   logic [15:0] imm16;
   logic        halted, illegal;

   int checks = 0;
   int errors = 0;

   cpu_mem_if #(.PC_W(8)) mem ();

   cpu_controller #(.PC_W(8), .RESET_PC(8'h10)) dut (
      .clk        (clk),
      .reset_n    (reset_n),
      .mem        (mem),
      .z_flag     (z_flag),
      .rf_rd_num  (rf_rd_num),
      .rf_wr_num  (rf_wr_num),
      .rf_write   (rf_write),
      .load_a     (load_a),
      .load_b     (load_b),
      .load_c     (load_c),
      .load_z     (load_z),
      .alu_op     (alu_op),
      .wb_sel_imm (wb_sel_imm),
      .imm16      (imm16),
      .halted     (halted),
      .illegal    (illegal)
   );

   always #5 clk = ~clk;

   initial begin
      #200000;
      $display("FAIL watchdog: observed=timeout required=finish");
      $fatal(1, "watchdog");
   end

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s: observed=0x%0h expected=0x%0h", tag, obs, exp);
      end
   endtask

   task automatic cyc();
      @(negedge clk);
   endtask

   // {rf_write, load_a, load_b, load_c, load_z, wb_sel_imm, mem_rd}
   function automatic logic [6:0] strobes();
      return {rf_write, load_a, load_b, load_c, load_z, wb_sel_imm, mem.mem_rd};
   endfunction

   task automatic fetch(input logic [15:0] instr, input int dly, input logic [7:0] exp_addr,
                        input string tag);
      int n = 0;
      while (mem.mem_rd !== 1'b1 && n < 20) begin
         @(negedge clk);
         n++;
      end
      chk({tag, "_rd"}, 32'(mem.mem_rd), 32'd1);
      chk({tag, "_addr"}, 32'(mem.mem_addr), 32'(exp_addr));
      for (int i = 0; i < dly; i++) begin
         @(negedge clk);
         chk({tag, "_addr_held"}, 32'({mem.mem_rd, mem.mem_addr}), 32'({1'b1, exp_addr}));
      end
      mem.mem_valid = 1'b1;
      mem.mem_rdata = instr;
      @(negedge clk);
      mem.mem_valid = 1'b0;
      mem.mem_rdata = 16'h0000;
   endtask

   initial begin
      reset_n       = 1'b0;
      z_flag        = 1'b0;
      mem.mem_valid = 1'b0;
      mem.mem_rdata = 16'h0000;
      repeat (3) cyc();
      chk("rst_strobes", 32'(strobes()), 32'd0);
      chk("rst_status", 32'({halted, illegal}), 32'd0);
      chk("rst_imm16", 32'(imm16), 32'd0);
      reset_n = 1'b1;
      cyc();
      chk("rel_mem_rd", 32'(mem.mem_rd), 32'd1);
      chk("rel_addr", 32'(mem.mem_addr), 32'h10);
      chk("rel_illegal", 32'(illegal), 32'd0);

      // MOV R1,#-6
      fetch(16'h01FA, 0, 8'h10, "mov1");
      chk("mov1_dec_wr", 32'(rf_write), 32'd0);
      cyc();
      chk("mov1_wb", 32'({rf_write, rf_wr_num, wb_sel_imm}), 32'({1'b1, 3'd1, 1'b1}));
      chk("mov1_imm", 32'(imm16), 32'hFFFA);
      cyc();
      chk("mov1_next", 32'({mem.mem_rd, mem.mem_addr, rf_write}), 32'({1'b1, 8'h11, 1'b0}));

      // MOV R2,#24
      fetch(16'h0218, 0, 8'h11, "mov2");
      cyc();
      chk("mov2_wb", 32'({rf_write, rf_wr_num, wb_sel_imm}), 32'({1'b1, 3'd2, 1'b1}));
      chk("mov2_imm", 32'(imm16), 32'h0018);
      cyc();
      chk("mov2_next", 32'({mem.mem_rd, mem.mem_addr}), 32'({1'b1, 8'h12}));

      // ADD R3=R1+R2 with a 3-cycle memory delay
      fetch(16'h2322, 3, 8'h12, "add");
      chk("add_dec", 32'(strobes()), 32'd0);
      cyc();
      chk("add_rda", 32'({load_a, load_b, rf_rd_num}), 32'({1'b1, 1'b0, 3'd1}));
      cyc();
      chk("add_rdb", 32'({load_a, load_b, rf_rd_num}), 32'({1'b0, 1'b1, 3'd2}));
      cyc();
      chk("add_exec", 32'({alu_op, load_c, load_z, rf_write}), 32'({2'b00, 1'b1, 1'b1, 1'b0}));
      cyc();
      chk("add_wb", 32'({rf_write, rf_wr_num, wb_sel_imm}), 32'({1'b1, 3'd3, 1'b0}));
      cyc();
      chk("add_next", 32'({mem.mem_rd, mem.mem_addr}), 32'({1'b1, 8'h13}));

      // CMP R1,R1 with AND in the op field: must still issue SUB
      fetch(16'h5021, 0, 8'h13, "cmp1");
      cyc();
      chk("cmp1_rda", 32'({load_a, rf_rd_num}), 32'({1'b1, 3'd1}));
      cyc();
      chk("cmp1_rdb", 32'({load_b, rf_rd_num}), 32'({1'b1, 3'd1}));
      cyc();
      chk("cmp1_exec", 32'({alu_op, load_c, load_z}), 32'({2'b01, 1'b1, 1'b1}));
      cyc();
      chk("cmp1_next", 32'({mem.mem_rd, mem.mem_addr, rf_write}), 32'({1'b1, 8'h14, 1'b0}));

      // B -17 from 0x14 -> 0x15-0x11 = 0x04
      fetch(16'h80EF, 0, 8'h14, "b_back");
      chk("b_back_dec", 32'(mem.mem_rd), 32'd0);
      cyc();
      chk("b_back_br", 32'(strobes()), 32'd0);
      cyc();
      chk("b_back_next", 32'({mem.mem_rd, mem.mem_addr}), 32'({1'b1, 8'h04}));

      // CMP R1,R1 at 0x04, then datapath reports Z=1
      fetch(16'h4021, 0, 8'h04, "cmp2");
      repeat (3) cyc();
      chk("cmp2_exec", 32'({alu_op, load_z}), 32'({2'b01, 1'b1}));
      z_flag = 1'b1;
      cyc();
      chk("cmp2_next", 32'({mem.mem_rd, mem.mem_addr}), 32'({1'b1, 8'h05}));

      // BEQ -3 at 0x05 taken -> 0x06-3 = 0x03
      fetch(16'h60FD, 0, 8'h05, "beq_t");
      cyc();
      cyc();
      chk("beq_t_next", 32'({mem.mem_rd, mem.mem_addr}), 32'({1'b1, 8'h03}));

      // BEQ -3 at 0x03 not taken -> 0x04
      z_flag = 1'b0;
      fetch(16'h60FD, 0, 8'h03, "beq_nt");
      cyc();
      cyc();
      chk("beq_nt_next", 32'({mem.mem_rd, mem.mem_addr}), 32'({1'b1, 8'h04}));

      // B -6 at 0x04 -> 0xFF, then B +1 at 0xFF wraps to 0x01
      fetch(16'h80FA, 0, 8'h04, "b_ff");
      cyc();
      cyc();
      chk("b_ff_next", 32'(mem.mem_addr), 32'hFF);
      fetch(16'h8001, 0, 8'hFF, "b_wrap");
      cyc();
      cyc();
      chk("b_wrap_next", 32'({mem.mem_rd, mem.mem_addr}), 32'({1'b1, 8'h01}));

      // opcode 101 at 0x01
      fetch(16'hA000, 0, 8'h01, "ill");
      chk("ill_dec_halted", 32'(halted), 32'd0);
      cyc();
`ifdef CPU_CTRL_ILLEGAL_TRAP_EN
      chk("ill_trap", 32'({halted, illegal, mem.mem_rd}), 32'({1'b1, 1'b1, 1'b0}));
      mem.mem_valid = 1'b1;
      mem.mem_rdata = 16'h01FA;
      repeat (3) cyc();
      mem.mem_valid = 1'b0;
      chk("ill_stuck", 32'({halted, illegal, strobes()}), 32'({1'b1, 1'b1, 7'd0}));
`else
      chk("ill_nop", 32'({mem.mem_rd, mem.mem_addr, illegal, halted}),
          32'({1'b1, 8'h02, 1'b0, 1'b0}));

      // HALT at 0x02, mem_valid while halted must be ignored
      fetch(16'hE000, 0, 8'h02, "halt");
      cyc();
      chk("halt_state", 32'({halted, strobes()}), 32'({1'b1, 7'd0}));
      mem.mem_valid = 1'b1;
      mem.mem_rdata = 16'h01FA;
      repeat (3) cyc();
      mem.mem_valid = 1'b0;
      chk("halt_stuck", 32'({halted, illegal, strobes(), mem.mem_addr}),
          32'({1'b1, 1'b0, 7'd0, 8'h03}));
`endif

      // reset out of HALT, then abort a MOV between DECODE and WB
      reset_n = 1'b0;
      cyc();
      chk("rehalt_rst", 32'({halted, illegal}), 32'd0);
      reset_n = 1'b1;
      cyc();
      chk("rerel", 32'({mem.mem_rd, mem.mem_addr}), 32'({1'b1, 8'h10}));
      fetch(16'h0305, 0, 8'h10, "abort");
      reset_n = 1'b0;
      #1;
      chk("abort_now", 32'({strobes(), imm16}), 32'd0);
      cyc();
      cyc();
      chk("abort_no_wb", 32'({rf_write, rf_wr_num}), 32'd0);
      reset_n = 1'b1;
      cyc();
      chk("abort_refetch", 32'({mem.mem_rd, mem.mem_addr}), 32'({1'b1, 8'h10}));

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule

// File: doc/cpu_controller.md
# cpu_controller

Multicycle control FSM for the 16-bit processor. It fetches instructions over a valid-qualified memory read handshake and decodes them. It sequences the register file, the A/B/C pipeline registers and the 2-bit-op ALU (ADD/SUB/AND/NOT-B), and consumes the registered Z status to resolve conditional branches. It is the issuing end of the ALU operation interface: it produces `alu_op` and consumes Z.

## Interface
- PC_W, 8, program counter / memory address width
- RESET_PC, 0, PC value loaded on reset
- clk  in  1  system clock, rising edge
- reset_n  in  1  asynchronous active-low reset
- mem_rd  out  1  instruction read request
- mem_addr  out  PC_W  read address (= pc)
- mem_valid  in  1  read data valid
- mem_rdata  in  16  instruction word
- z_flag  in  1  registered ALU Z status from datapath
- rf_rd_num  out  3  register file read select
- rf_wr_num  out  3  register file write select
- rf_write  out  1  register file write enable
- load_a / load_b / load_c / load_z  out  1 each  datapath register enables
- alu_op  out  2  00 ADD, 01 SUB, 10 AND, 11 NOT B
- wb_sel_imm  out  1  writeback source: 1 = imm16, 0 = C
- imm16  out  16  sign-extended imm8
- halted  out  1  controller stopped
- illegal  out  1  sticky, illegal opcode trapped

## Operation
- Instruction fields: [15:13] opcode, [12:11] alu op, [10:8] Rd, [7:5] Rn, [2:0] Rm, [7:0] imm8.
- Opcodes: 000 MOV (Rd <= sx(imm8)), 001 ALU (Rd <= Rn op Rm), 010 CMP (Rn − Rm, Z only), 011 BEQ, 100 B, 111 HALT; 101/110 illegal.
- States: FETCH, DECODE, READ_A, READ_B, EXEC, WB, BRANCH, HALT.
- FETCH: mem_rd=1. On mem_valid, IR<=mem_rdata and pc<=pc+1, then go to DECODE.
- DECODE: MOV→WB; ALU/CMP→READ_A; BEQ/B→BRANCH; HALT→HALT; illegal→see Configuration.
- READ_A: rf_rd_num=Rn, load_a. READ_B: rf_rd_num=Rm, load_b.
- EXEC: alu_op=IR[12:11], load_c, load_z. CMP forces alu_op=01. CMP goes to FETCH; ALU goes to WB.
- WB: rf_write, rf_wr_num=Rd, wb_sel_imm=1 for MOV, else 0. Then go to FETCH.
- BRANCH: B, or BEQ with z_flag=1: pc<=pc+sx(imm8), relative to the incremented pc. Otherwise pc is unchanged. Then go to FETCH.
- pc arithmetic is modulo 2^PC_W and wraps silently. imm8 is sign-extended before truncation to PC_W.
- HALT is absorbing until reset. halted=1 and all strobes are 0.
- All strobes are Moore outputs, decoded from state and IR only. The decode of the illegal opcodes (101/110) depends on CPU_CTRL_ILLEGAL_TRAP_EN.

## Timing
- Reset (asynchronous assert, synchronous release): state=FETCH, pc=RESET_PC, IR=0, illegal=0. All strobes are 0 and halted=0. mem_rd rises in the first cycle after release.
- mem_addr and mem_rd are held stable until the cycle mem_valid is sampled high. mem_valid outside FETCH is ignored.
- Cycles from mem_valid high to the next FETCH entry: ALU 5, CMP 4, MOV 2, branch 2.
- A write in WB is visible to the next instruction's READ_A/READ_B.
- z_flag is sampled in BRANCH. A CMP immediately before BEQ is therefore valid, because load_z landed in EXEC.
- Reset mid-fetch or mid-instruction aborts immediately. No partial writeback occurs after the reset edge.

## Configuration
- CPU_CTRL_ILLEGAL_TRAP_EN defined: opcodes 101/110 go DECODE→HALT, set illegal=1 and assert halted.
- Not defined: 101/110 execute as NOP (DECODE→FETCH). illegal is tied to 0.

## Structure
- cpu_pkg holds opcode constants, ALU op codes (shared with the ALU and its bench), the state encoding, and the field bit positions.
- One combinational sub-module, cpu_instr_decode, extracts fields, sign-extends imm8 and classifies the opcode. The FSM, pc and IR live in cpu_controller.

## Test plan
- Reset with RESET_PC=0x10, release → mem_rd=1, mem_addr=0x10. All strobes and illegal read 0.
- MOV R1,#−6 (0x01FA) then MOV R2,#24 → rf_write with rf_wr_num=1 and imm16=0xFFFA, then rf_wr_num=2 and imm16=0x0018, each exactly 2 cycles after mem_valid.
- ALU ADD R3=R1+R2, with mem_valid delayed 3 cycles → mem_addr held stable through the delay. Sequence is load_a(Rn=1), load_b(Rm=2), alu_op=00 with load_c/load_z, then rf_write with rf_wr_num=3. Total is 5 cycles.
- CMP R1,R1, then datapath drives z_flag=1, then BEQ −3 at pc=0x05 → pc becomes 0x03 (0x06−3). With z_flag=0 the next fetch address is 0x06.
- B +1 at pc=0xFF with PC_W=8 → next fetch address 0x01 (wrap).
- Opcode 101: with the macro, halted=1 and illegal=1 and mem_rd stays 0. Without the macro, the next fetch occurs at pc+1.
